riscv_rf_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the core's integer register file (one write port, two combinational read ports, x0 hardwired to zero). It merges single-cycle ALU writebacks and variable-latency LSU load returns onto the single write port, buffering LSU results in a small FIFO. It tracks destination registers with outstanding loads and raises a hazard stall toward decode. It sits between the execute/LSU stages and the register file.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/riscv_rf_wb_arbiter_if.sv | 48 ++++
 rtl/riscv_rf_wb_fifo.sv | 61 ++++++
 rtl/riscv_rf_wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core types: register-index geometry and writeback arbitration enums.
// Pure declarations; no logic, no latency, no flow control.
package riscv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        HOLD   = 1'b1
    } arb_state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

endpackage

// File: rtl/riscv_rf_wb_arbiter_if.sv
// Writeback/scoreboard bundle between execute/LSU/decode and the regfile write port.
// master = pipeline side, slave = arbiter side.
interface riscv_rf_wb_arbiter_if #(
    parameter int XLEN = 32
);
    import riscv_pkg::*;

    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [XLEN-1:0]      alu_data;
    logic                 alu_hold;

    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [REG_IDX_W-1:0] lsu_rd;
    logic [XLEN-1:0]      lsu_data;

    logic                 issue_valid;
    logic [REG_IDX_W-1:0] issue_rd;

    logic [REG_IDX_W-1:0] chk_a1;
    logic [REG_IDX_W-1:0] chk_a2;
    logic [REG_IDX_W-1:0] chk_rd;
    logic                 hazard;

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_a3;
    logic [XLEN-1:0]      rf_wd3;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        output chk_a1, chk_a2, chk_rd,
        input  alu_hold, lsu_ready, hazard,
        input  rf_we, rf_a3, rf_wd3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        input  chk_a1, chk_a2, chk_rd,
        output alu_hold, lsu_ready, hazard,
        output rf_we, rf_a3, rf_wd3
    );

endinterface

// File: rtl/riscv_rf_wb_fifo.sv
// Synchronous FIFO for buffered load returns; head visible combinationally, one-edge push-to-head.
// full/empty are registered; push while full and pop while empty are ignored.
module riscv_rf_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Merges ALU writebacks and buffered LSU returns onto one registered regfile write port, tracks pending loads.
// Optional RF_ARB_PERF_EN adds conflict_cnt; lsu_ready drops on registered FIFO full, alu_hold forces an LSU slot.
module riscv_rf_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_rf_wb_arbiter_if.slave  bus
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]           conflict_cnt
`endif
);
    localparam int EW = REG_IDX_W + XLEN;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [SW-1:0]        starve_cnt;
    logic [SW-1:0]        starve_cnt_nxt;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_head;
    logic [REG_IDX_W-1:0] head_rd;
    logic [XLEN-1:0]      head_data;

    logic                 alu_req;
    logic                 lsu_keep;
    logic                 alu_win;
    logic                 wr_en;
    wb_src_e              wr_src;
    logic [REG_IDX_W-1:0] wr_rd;
    logic [XLEN-1:0]      wr_dat;

    logic                 rf_we_q;
    wb_src_e              rf_src_q;
    logic [REG_IDX_W-1:0] rf_a3_q;
    logic [XLEN-1:0]      rf_wd3_q;
    logic                 lsu_out;

    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  set_vec;
    logic [NUM_REGS-1:0]  clr_vec;

    riscv_rf_wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({bus.lsu_rd, bus.lsu_data}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_rd, head_data} = fifo_head;
    assign bus.lsu_ready = !fifo_full;
    assign bus.alu_hold  = (state == HOLD);
    assign alu_req  = bus.alu_valid && (bus.alu_rd != '0) && (state == NORMAL);
    assign lsu_keep = bus.lsu_valid && !fifo_full && (bus.lsu_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if (wr_en && wr_src == SRC_LSU)
            starve_cnt_nxt = '0;
        else if (alu_win && !fifo_empty && starve_cnt != SW'(STARVE_LIMIT - 1))
            starve_cnt_nxt = starve_cnt + 1'b1;
        case (state)
            NORMAL:  if (alu_win && !fifo_empty && starve_cnt == SW'(STARVE_LIMIT - 1))
                         state_nxt = HOLD;
            HOLD:    state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // Port owner: HOLD drains the head; otherwise ALU, then FIFO head, then cut-through beat.
    always_comb begin
        alu_win   = 1'b0;
        wr_en     = 1'b0;
        wr_src    = SRC_ALU;
        wr_rd     = bus.alu_rd;
        wr_dat    = bus.alu_data;
        fifo_pop  = 1'b0;
        fifo_push = lsu_keep;
        if (state == HOLD) begin
            wr_en    = !fifo_empty;
            wr_src   = SRC_LSU;
            wr_rd    = head_rd;
            wr_dat   = head_data;
            fifo_pop = 1'b1;
        end else if (alu_req) begin
            alu_win = 1'b1;
            wr_en   = 1'b1;
        end else if (!fifo_empty) begin
            wr_en    = 1'b1;
            wr_src   = SRC_LSU;
            wr_rd    = head_rd;
            wr_dat   = head_data;
            fifo_pop = 1'b1;
        end else if (lsu_keep) begin
            wr_en     = 1'b1;
            wr_src    = SRC_LSU;
            wr_rd     = bus.lsu_rd;
            wr_dat    = bus.lsu_data;
            fifo_push = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q  <= 1'b0;
            rf_src_q <= SRC_ALU;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
        end else begin
            rf_we_q <= wr_en;
            if (wr_en) begin
                rf_src_q <= wr_src;
                rf_a3_q  <= wr_rd;
                rf_wd3_q <= wr_dat;
            end
        end
    end

    assign bus.rf_we  = rf_we_q;
    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_wd3 = rf_wd3_q;
    assign lsu_out    = rf_we_q && (rf_src_q == SRC_LSU);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.issue_valid) set_vec[bus.issue_rd] = 1'b1;
        if (lsu_out)         clr_vec[rf_a3_q]      = 1'b1;
    end

    // Set is applied after clear so a same-edge reissue keeps the bit; x0 is masked.
    always_ff @(posedge clk) begin
        if (!rst_n) pending <= '0;
        else        pending <= ((pending & ~clr_vec) | set_vec) & {{(NUM_REGS-1){1'b1}}, 1'b0};
    end

    assign bus.hazard = pending[bus.chk_a1] | pending[bus.chk_a2] | pending[bus.chk_rd]
                      | (lsu_out && (rf_a3_q == bus.chk_a1 || rf_a3_q == bus.chk_a2 ||
                                     rf_a3_q == bus.chk_rd));

`ifdef RF_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (alu_win && (!fifo_empty || lsu_keep))
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif

    hold_blocks_alu: assert property (@(posedge clk) disable iff (!rst_n)
                                      !((state == HOLD) && bus.alu_valid));

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Directed bench for riscv_rf_wb_arbiter: reset, ALU path, load hazard, starvation hold, set-wins, reset flush.
module tb_riscv_rf_wb_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] rf_model [32];

    riscv_rf_wb_arbiter_if #(.XLEN(32)) bus ();

`ifdef RF_ARB_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    riscv_rf_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef RF_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_we) rf_model[bus.rf_a3] <= bus.rf_wd3;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = rd;
        bus.lsu_data  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.chk_a1 = 5'd7;
        bus.chk_a2 = 5'd0;
        bus.chk_rd = 5'd0;
        @(negedge clk);
        do_reset();
        check_eq("rst_rf_we",     32'(bus.rf_we),     32'd0);
        check_eq("rst_rf_a3",     32'(bus.rf_a3),     32'd0);
        check_eq("rst_rf_wd3",    bus.rf_wd3,         32'd0);
        check_eq("rst_alu_hold",  32'(bus.alu_hold),  32'd0);
        check_eq("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        check_eq("rst_hazard",    32'(bus.hazard),    32'd0);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_no_we", 32'(bus.rf_we), 32'd0);

        // ALU write, then a dropped write to x0.
        alu(5'd5, 32'h1234);
        step();
        check_eq("alu_we",  32'(bus.rf_we), 32'd1);
        check_eq("alu_a3",  32'(bus.rf_a3), 32'd5);
        check_eq("alu_wd3", bus.rf_wd3,     32'h1234);
        alu(5'd0, 32'hFFFF);
        step();
        check_eq("alu_x0_no_we", 32'(bus.rf_we), 32'd0);
        idle();

        // Load to x7 returns three cycles after issue with the ALU idle.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        check_eq("ld_haz_pre", 32'(bus.hazard), 32'd0);
        step();
        bus.issue_valid = 1'b0;
        check_eq("ld_haz_c1", 32'(bus.hazard), 32'd1);
        step();
        check_eq("ld_haz_c2", 32'(bus.hazard), 32'd1);
        step();
        check_eq("ld_haz_c3", 32'(bus.hazard), 32'd1);
        lsu(5'd7, 32'hDEAD);
        step();
        idle();
        check_eq("ld_we",     32'(bus.rf_we),  32'd1);
        check_eq("ld_a3",     32'(bus.rf_a3),  32'd7);
        check_eq("ld_wd3",    bus.rf_wd3,      32'hDEAD);
        check_eq("ld_haz_we", 32'(bus.hazard), 32'd1);
        step();
        check_eq("ld_haz_clr", 32'(bus.hazard), 32'd0);
        check_eq("ld_rf_read", rf_model[7],     32'hDEAD);

        // Starvation: ALU every cycle while two beats fill the FIFO.
        bus.chk_a1 = 5'd0;
        do_reset();
        rst_n = 1'b1;
        alu(5'd1, 32'h100);
        lsu(5'd10, 32'hA0A0);
        step();
        check_eq("st_ready_c1", 32'(bus.lsu_ready), 32'd1);
        alu(5'd2, 32'h200);
        lsu(5'd11, 32'hB1B1);
        step();
        check_eq("st_ready_full", 32'(bus.lsu_ready), 32'd0);
        check_eq("st_alu_a3_c2",  32'(bus.rf_a3),     32'd2);
        bus.lsu_valid = 1'b0;
        alu(5'd3, 32'h300);
        step();
        alu(5'd4, 32'h400);
        step();
        check_eq("st_hold_c4", 32'(bus.alu_hold), 32'd0);
        alu(5'd5, 32'h500);
        step();
        check_eq("st_hold_c5", 32'(bus.alu_hold), 32'd1);
        check_eq("st_a3_c5",   32'(bus.rf_a3),    32'd5);
        bus.alu_valid = 1'b0;
        step();
        check_eq("st_hold_c6",   32'(bus.alu_hold),  32'd0);
        check_eq("st_head_we",   32'(bus.rf_we),     32'd1);
        check_eq("st_head_a3",   32'(bus.rf_a3),     32'd10);
        check_eq("st_head_wd3",  bus.rf_wd3,         32'hA0A0);
        check_eq("st_ready_c6",  32'(bus.lsu_ready), 32'd1);
        step();
        check_eq("st_head2_a3",  32'(bus.rf_a3),     32'd11);
        check_eq("st_head2_wd3", bus.rf_wd3,         32'hB1B1);
`ifdef RF_ARB_PERF_EN
        check_eq("perf_conflicts", conflict_cnt, 32'd5);
`endif

        // A load return to x0 is accepted and discarded.
        lsu(5'd0, 32'h5555);
        step();
        idle();
        check_eq("lsu_x0_no_we_c1", 32'(bus.rf_we), 32'd0);
        step();
        check_eq("lsu_x0_no_we_c2", 32'(bus.rf_we), 32'd0);

        // Reissue of x9 on the edge its previous load lands keeps it pending.
        bus.chk_rd      = 5'd9;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        lsu(5'd9, 32'h99);
        step();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        check_eq("sw_we", 32'(bus.rf_we), 32'd1);
        check_eq("sw_a3", 32'(bus.rf_a3), 32'd9);
        step();
        bus.issue_valid = 1'b0;
        check_eq("sw_haz_c3", 32'(bus.hazard), 32'd1);
        step();
        check_eq("sw_haz_c4", 32'(bus.hazard), 32'd1);

        // Reset mid-operation drops the buffered beat and pending bits.
        alu(5'd3, 32'h333);
        lsu(5'd12, 32'hC0C0);
        step();
        do_reset();
        check_eq("mid_rst_haz",   32'(bus.hazard),    32'd0);
        check_eq("mid_rst_ready", 32'(bus.lsu_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check_eq("mid_rst_no_we_c1", 32'(bus.rf_we), 32'd0);
        step();
        check_eq("mid_rst_no_we_c2", 32'(bus.rf_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
